// File: rtl/berg_link_serdes_if.sv
// berg_link_serdes_if: bundles the word-side handshakes and both link
// directions of one board end. Optional parity pins exist only when
// LINK_PARITY_EN is defined.
//
// Handshake semantics: a tx word transfers on a rising edge where
// tx_valid and tx_ready are both high; tx_data must be stable at that edge.
// Link beats carry no back-pressure: a beat is consumed on every edge where
// link_*_strb is high. rx_valid and rx_err are single-cycle pulses with no
// ready; the receiver of those pulses must always sample them.
interface berg_link_serdes_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [LANES-1:0]  link_out_data;
  logic              link_out_strb;
  logic              link_out_first;
  logic [LANES-1:0]  link_in_data;
  logic              link_in_strb;
  logic              link_in_first;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
`ifdef LINK_PARITY_EN
  logic              link_out_par;
  logic              link_in_par;

  modport slave (
    input  tx_data, tx_valid, link_in_data, link_in_strb, link_in_first, link_in_par,
    output tx_ready, link_out_data, link_out_strb, link_out_first, link_out_par,
           rx_data, rx_valid, rx_err
  );
  modport master (
    output tx_data, tx_valid, link_in_data, link_in_strb, link_in_first, link_in_par,
    input  tx_ready, link_out_data, link_out_strb, link_out_first, link_out_par,
           rx_data, rx_valid, rx_err
  );
`else
  modport slave (
    input  tx_data, tx_valid, link_in_data, link_in_strb, link_in_first,
    output tx_ready, link_out_data, link_out_strb, link_out_first,
           rx_data, rx_valid, rx_err
  );
  modport master (
    output tx_data, tx_valid, link_in_data, link_in_strb, link_in_first,
    input  tx_ready, link_out_data, link_out_strb, link_out_first,
           rx_data, rx_valid, rx_err
  );
`endif
endinterface

// File: rtl/berg_link_serdes.sv
// berg_link_serdes: carries a DATA_W-bit word over LANES link pins in
// BEATS = DATA_W/LANES beats, LSB lanes first, framed by strobe and a
// first-beat marker. Tx and rx halves are independent.
// Optional feature macro: LINK_PARITY_EN (even parity per beat).
module berg_link_serdes #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic               clk,
  input  logic               rst,
  berg_link_serdes_if.slave  bus,
  output logic [1:0]         dbg_tx_state,
  output logic               dbg_rx_state
);
  localparam int BEATS = DATA_W / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST     = CW'(BEATS - 1);
  localparam logic [3:0]    GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_GAP = 2'd2} tx_state_t;
  typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;

  // ---------------- transmit side ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              ready_q, ready_d;
  logic [LANES-1:0]  od_q, od_d;
  logic              strb_q, strb_d, first_q, first_d;

  // Tx state and registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tx_sh_q    <= '0;
      ready_q    <= 1'b0;
      od_q       <= '0;
      strb_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_sh_q    <= tx_sh_d;
      ready_q    <= ready_d;
      od_q       <= od_d;
      strb_q     <= strb_d;
      first_q    <= first_d;
    end
  end

  // Tx next state: beat 0 is registered at the accept edge, so the last
  // beat is on the pins while the counter sits at LAST.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_sh_d    = tx_sh_q;
    ready_d    = 1'b0;
    od_d       = '0;
    strb_d     = 1'b0;
    first_d    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        ready_d = 1'b1;
        if (bus.tx_valid && ready_q) begin
          tx_sh_d    = bus.tx_data >> LANES;
          od_d       = bus.tx_data[LANES-1:0];
          strb_d     = 1'b1;
          first_d    = 1'b1;
          tx_cnt_d   = '0;
          ready_d    = 1'b0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == LAST) begin
          if (IDLE_GAP > 0) begin
            tx_state_d = TX_GAP;
            gap_cnt_d  = '0;
          end else begin
            tx_state_d = TX_IDLE;
            ready_d    = 1'b1;
          end
        end else begin
          od_d     = tx_sh_q[LANES-1:0];
          tx_sh_d  = tx_sh_q >> LANES;
          strb_d   = 1'b1;
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          tx_state_d = TX_IDLE;
          ready_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign bus.tx_ready       = ready_q;
  assign bus.link_out_data  = od_q;
  assign bus.link_out_strb  = strb_q;
  assign bus.link_out_first = first_q;
`ifdef LINK_PARITY_EN
  assign bus.link_out_par   = ^od_q;
`endif

  // ---------------- receive side ----------------
  rx_state_t         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d, asm_ins;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [CW-1:0]     rx_sel;
  logic              par_ok;

  // Rx state, assembly buffer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      asm_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      asm_q      <= asm_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Rx next state: a first beat always (re)starts a frame; a bad-parity beat
  // drops the whole frame so a partial word never reaches rx_data.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    asm_d      = asm_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
`ifdef LINK_PARITY_EN
    par_ok = (bus.link_in_par == ^bus.link_in_data);
`else
    par_ok = 1'b1;
`endif
    rx_sel  = bus.link_in_first ? '0 : rx_cnt_q;
    asm_ins = asm_q;
    for (int b = 0; b < BEATS; b++) begin
      if (rx_sel == CW'(b)) asm_ins[b*LANES +: LANES] = bus.link_in_data;
    end
    if (bus.link_in_strb) begin
      if (!par_ok) begin
        rx_err_d   = 1'b1;
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end else if (bus.link_in_first) begin
        rx_err_d = (rx_state_q == RX_RECV);
        asm_d    = asm_ins;
        if (BEATS == 1) begin
          rx_data_d  = asm_ins;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d   = CW'(1);
          rx_state_d = RX_RECV;
        end
      end else if (rx_state_q == RX_RECV) begin
        asm_d = asm_ins;
        if (rx_cnt_q == LAST) begin
          rx_data_d  = asm_ins;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end else begin
        rx_err_d = 1'b1;
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;

  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;
endmodule

// File: tb/tb_berg_link_serdes.sv
// tb_berg_link_serdes: two link ends (IDLE_GAP 0 and 2), each looped back;
// end A can also have its receive pins driven directly by the bench.
`timescale 1ns/1ps
module tb_berg_link_serdes;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int BEATS  = DATA_W / LANES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  berg_link_serdes_if #(.DATA_W(DATA_W), .LANES(LANES)) a_if ();
  berg_link_serdes_if #(.DATA_W(DATA_W), .LANES(LANES)) b_if ();
  logic [1:0] a_txs, b_txs;
  logic       a_rxs, b_rxs;

  logic             a_loop    = 1'b1;
  logic [LANES-1:0] drv_data  = '0;
  logic             drv_strb  = 1'b0;
  logic             drv_first = 1'b0;
  logic             drv_flip  = 1'b0;

  assign a_if.link_in_data  = a_loop ? a_if.link_out_data  : drv_data;
  assign a_if.link_in_strb  = a_loop ? a_if.link_out_strb  : drv_strb;
  assign a_if.link_in_first = a_loop ? a_if.link_out_first : drv_first;
  assign b_if.link_in_data  = b_if.link_out_data;
  assign b_if.link_in_strb  = b_if.link_out_strb;
  assign b_if.link_in_first = b_if.link_out_first;
`ifdef LINK_PARITY_EN
  assign a_if.link_in_par = a_loop ? a_if.link_out_par : ((^drv_data) ^ drv_flip);
  assign b_if.link_in_par = b_if.link_out_par;
`endif

  berg_link_serdes #(.DATA_W(DATA_W), .LANES(LANES), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave), .dbg_tx_state(a_txs), .dbg_rx_state(a_rxs)
  );
  berg_link_serdes #(.DATA_W(DATA_W), .LANES(LANES), .IDLE_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave), .dbg_tx_state(b_txs), .dbg_rx_state(b_rxs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  // Expected words in send order, with the cycle their rx_valid is due
  // (-1 when the bench drives rx pins by hand and timing is not modelled).
  logic [DATA_W-1:0] exp_a[$];
  int                due_a[$];
  logic [DATA_W-1:0] exp_b[$];
  int                due_b[$];
  int val_a = 0, err_a = 0, val_b = 0, err_b = 0;
  logic [DATA_W-1:0] mw_a, mw_b;
  int                md_a, md_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.rx_valid) begin
        val_a++;
        check("a_valid_err_exclusive", 32'(a_if.rx_err), 32'd0);
        if (exp_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_word: got 0x%0h expected none", a_if.rx_data);
        end else begin
          mw_a = exp_a.pop_front();
          md_a = due_a.pop_front();
          check("a_rx_data", 32'(a_if.rx_data), 32'(mw_a));
          if (md_a >= 0) check("a_rx_latency", cyc, md_a);
        end
      end
      if (a_if.rx_err) err_a++;
      if (b_if.rx_valid) begin
        val_b++;
        check("b_valid_err_exclusive", 32'(b_if.rx_err), 32'd0);
        if (exp_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_word: got 0x%0h expected none", b_if.rx_data);
        end else begin
          mw_b = exp_b.pop_front();
          md_b = due_b.pop_front();
          check("b_rx_data", 32'(b_if.rx_data), 32'(mw_b));
          if (md_b >= 0) check("b_rx_latency", cyc, md_b);
        end
      end
      if (b_if.rx_err) err_b++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with tx_valid already high; returns the cycle
  // number of the accept edge.
  task automatic wait_ready(input bit which, output int acc);
    int n = 0;
    while (!(which ? b_if.tx_ready : a_if.tx_ready) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL tx_ready_timeout: got 0 expected 1");
    end
    acc = cyc + 1;
  endtask

  task automatic send(input bit which, input logic [DATA_W-1:0] w, input bit push, output int acc);
    @(negedge clk);
    if (which) begin b_if.tx_data = w; b_if.tx_valid = 1'b1; end
    else       begin a_if.tx_data = w; a_if.tx_valid = 1'b1; end
    wait_ready(which, acc);
    if (push) begin
      if (which) begin exp_b.push_back(w); due_b.push_back(acc + BEATS); end
      else       begin exp_a.push_back(w); due_a.push_back(acc + BEATS); end
    end
    @(posedge clk);
    #1;
    if (which) b_if.tx_valid = 1'b0; else a_if.tx_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [LANES-1:0] d, input bit s, input bit f, input bit flip);
    @(negedge clk);
    drv_data  = s ? d : '0;
    drv_strb  = s;
    drv_first = f;
    drv_flip  = flip;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_beat('0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [DATA_W-1:0] word;
    logic [LANES-1:0]  beat [4];
  } vec_t;
  vec_t vecs [5];

  int acc, acc1, acc2, v0, e0;
  logic [DATA_W-1:0] rw;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].word = 16'hA5C3; vecs[0].beat = '{4'h3, 4'hC, 4'h5, 4'hA};
    vecs[1].word = 16'h1234; vecs[1].beat = '{4'h4, 4'h3, 4'h2, 4'h1};
    vecs[2].word = 16'hFFFF; vecs[2].beat = '{4'hF, 4'hF, 4'hF, 4'hF};
    vecs[3].word = 16'h0000; vecs[3].beat = '{4'h0, 4'h0, 4'h0, 4'h0};
    vecs[4].word = 16'h8001; vecs[4].beat = '{4'h1, 4'h0, 4'h0, 4'h8};

    a_if.tx_data = '0; a_if.tx_valid = 1'b0;
    b_if.tx_data = '0; b_if.tx_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(a_if.tx_ready), 32'd0);
    check("rst_strb", 32'(a_if.link_out_strb), 32'd0);
    check("rst_first", 32'(a_if.link_out_first), 32'd0);
    check("rst_link_data", 32'(a_if.link_out_data), 32'd0);
    check("rst_rx_data", 32'(a_if.rx_data), 32'd0);
    check("rst_rx_valid", 32'(a_if.rx_valid), 32'd0);
    check("rst_rx_err", 32'(a_if.rx_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rises", 32'(a_if.tx_ready), 32'd1);
    check("rst_b_ready_rises", 32'(b_if.tx_ready), 32'd1);

    // Table-driven loopback words on end A (IDLE_GAP=0)
    for (int i = 0; i < 5; i++) begin
      send(1'b0, vecs[i].word, 1'b1, acc);
      for (int b = 0; b < BEATS; b++) begin
        @(negedge clk);
        check($sformatf("vec%0d_beat%0d_data", i, b), 32'(a_if.link_out_data), 32'(vecs[i].beat[b]));
        check($sformatf("vec%0d_beat%0d_first", i, b), 32'(a_if.link_out_first), (b == 0) ? 32'd1 : 32'd0);
        check($sformatf("vec%0d_beat%0d_strb", i, b), 32'(a_if.link_out_strb), 32'd1);
        check($sformatf("vec%0d_beat%0d_ready_low", i, b), 32'(a_if.tx_ready), 32'd0);
      end
      @(negedge clk);
      check($sformatf("vec%0d_strb_end", i), 32'(a_if.link_out_strb), 32'd0);
      check($sformatf("vec%0d_data_end", i), 32'(a_if.link_out_data), 32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(a_if.tx_ready), 32'd1);
    end

    // Back-to-back on end B (IDLE_GAP=2) with tx_valid held
    e0 = err_b;
    @(negedge clk);
    b_if.tx_data = 16'h1234; b_if.tx_valid = 1'b1;
    wait_ready(1'b1, acc1);
    exp_b.push_back(16'h1234); due_b.push_back(acc1 + BEATS);
    @(posedge clk);
    #1;
    b_if.tx_data = 16'hFFFF;
    @(negedge clk);
    wait_ready(1'b1, acc2);
    exp_b.push_back(16'hFFFF); due_b.push_back(acc2 + BEATS);
    @(posedge clk);
    #1;
    b_if.tx_valid = 1'b0;
    check("b2b_accept_period", acc2 - acc1, 32'd7);
    repeat (10) @(negedge clk);
    check("b2b_no_err", err_b - e0, 32'd0);
    check("b2b_both_received", 32'(exp_b.size()), 32'd0);

    // Randomized loopback traffic on both ends
    for (int i = 0; i < 40; i++) begin
      rw = 16'($urandom);
      send(1'($urandom_range(0, 1)), rw, 1'b1, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (14) @(negedge clk);
    check("rand_a_drained", 32'(exp_a.size()), 32'd0);
    check("rand_b_drained", 32'(exp_b.size()), 32'd0);
    check("rand_no_err_a", 32'(err_a), 32'd0);
    check("rand_no_err_b", 32'(err_b), 32'd0);

    // Reset during tx beat 1 (word 0x5A5A: beats A,5,A,5)
    v0 = val_a;
    send(1'b0, 16'h5A5A, 1'b0, acc);
    @(negedge clk);
    check("rstmid_beat0_strb", 32'(a_if.link_out_strb), 32'd1);
    @(negedge clk);
    check("rstmid_beat1_data", 32'(a_if.link_out_data), 32'h5);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_strb_drop", 32'(a_if.link_out_strb), 32'd0);
    check("rstmid_ready_low", 32'(a_if.tx_ready), 32'd0);
    check("rstmid_rx_data_clear", 32'(a_if.rx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_back", 32'(a_if.tx_ready), 32'd1);
    check("rstmid_strb_still_low", 32'(a_if.link_out_strb), 32'd0);
    repeat (6) @(negedge clk);
    check("rstmid_no_partial_rx", val_a - v0, 32'd0);

    // Receive side driven by hand
    @(negedge clk);
    a_loop = 1'b0;
    v0 = val_a; e0 = err_a;
    exp_a.push_back(16'h4321); due_a.push_back(-1);
    drive_beat(4'h1, 1'b1, 1'b1, 1'b0);
    drive_idle(3);
    drive_beat(4'h2, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h3, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h4, 1'b1, 1'b0, 1'b0);
    drive_idle(3);
    check("gap_one_valid", val_a - v0, 32'd1);
    check("gap_no_err", err_a - e0, 32'd0);
    check("gap_rx_data", 32'(a_if.rx_data), 32'h4321);

    // First marker at beat 2 restarts the frame
    v0 = val_a; e0 = err_a;
    exp_a.push_back(16'hDB69); due_a.push_back(-1);
    drive_beat(4'h7, 1'b1, 1'b1, 1'b0);
    drive_beat(4'h8, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h9, 1'b1, 1'b1, 1'b0);
    drive_beat(4'h6, 1'b1, 1'b0, 1'b0);
    drive_beat(4'hB, 1'b1, 1'b0, 1'b0);
    drive_beat(4'hD, 1'b1, 1'b0, 1'b0);
    drive_idle(3);
    check("restart_one_err", err_a - e0, 32'd1);
    check("restart_one_valid", val_a - v0, 32'd1);
    check("restart_rx_data", 32'(a_if.rx_data), 32'hDB69);

    // Continuation beat while idle
    v0 = val_a; e0 = err_a;
    drive_beat(4'h5, 1'b1, 1'b0, 1'b0);
    drive_idle(3);
    check("stray_err", err_a - e0, 32'd1);
    check("stray_no_valid", val_a - v0, 32'd0);
    check("stray_rx_data_held", 32'(a_if.rx_data), 32'hDB69);

`ifdef LINK_PARITY_EN
    // Bad parity on beat 3, then a clean frame
    v0 = val_a; e0 = err_a;
    drive_beat(4'h7, 1'b1, 1'b1, 1'b0);
    drive_beat(4'h5, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h3, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h1, 1'b1, 1'b0, 1'b1);
    drive_idle(3);
    check("par_err", err_a - e0, 32'd1);
    check("par_no_valid", val_a - v0, 32'd0);
    check("par_rx_data_held", 32'(a_if.rx_data), 32'hDB69);
    v0 = val_a; e0 = err_a;
    exp_a.push_back(16'h2468); due_a.push_back(-1);
    drive_beat(4'h8, 1'b1, 1'b1, 1'b0);
    drive_beat(4'h6, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h4, 1'b1, 1'b0, 1'b0);
    drive_beat(4'h2, 1'b1, 1'b0, 1'b0);
    drive_idle(3);
    check("par_clean_valid", val_a - v0, 32'd1);
    check("par_clean_no_err", err_a - e0, 32'd0);
`endif

    a_loop = 1'b1;
    repeat (4) @(negedge clk);
    check("final_a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("final_b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/berg_link_serdes.md
Name: berg_link_serdes

Overview:
- Parametrised successor to the board-connector pass-through models used in sim_ttl.
- Instead of wiring each signal to its own connector pin, it carries a DATA_W-bit word over a narrow LANES-bit header in BEATS = DATA_W/LANES beats.
- Framing uses a strobe and a first-beat marker. The receive side reassembles words and flags framing errors.
- Instantiated once per board end. Tx and rx sides are independent and can be looped back externally.

Parameters:
- DATA_W, 16, word width; must be a multiple of LANES.
- LANES, 4, data pins per direction; 1..DATA_W.
- IDLE_GAP, 0, idle cycles the tx inserts after each frame before accepting the next word (0..15).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to send; sampled on the accept edge.
- tx_valid  in  1  tx word offered.
- tx_ready  out  1  tx can accept; high only in IDLE.
- link_out_data  out  LANES  lane bits of the current beat.
- link_out_strb  out  1  beat valid on link_out_data.
- link_out_first  out  1  marks beat 0 of a frame.
- link_in_data  in  LANES  received lane bits.
- link_in_strb  in  1  received beat valid.
- link_in_first  in  1  received beat is beat 0.
- rx_data  out  DATA_W  last correctly received word; held between frames.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_err  out  1  one-cycle pulse on a framing or parity error.

Behaviour:
- Reset (rst high at an edge):
  - Outputs after that edge: tx_ready=0, link_out_*=0, rx_data=0, rx_valid=0, rx_err=0.
  - Both FSMs go to IDLE and beat counters clear.
  - tx_ready rises the first edge after rst deasserts.
  - Reset mid-frame abandons the frame: no further beats, no rx_valid for the partial word.
- TX FSM, states IDLE, SEND, GAP:
  - IDLE: tx_ready=1. On tx_valid&tx_ready, latch tx_data into the shift register, beat counter=0, go to SEND.
  - SEND: outputs are registered, so beat b appears in the cycle after edge b of SEND.
    - link_out_data = word[(b+1)*LANES-1 : b*LANES], LSB lanes first.
    - link_out_strb=1.
    - link_out_first=1 only for b=0.
    - After beat BEATS-1, go to GAP if IDLE_GAP>0, else IDLE.
  - GAP: strb=0 for IDLE_GAP cycles, then IDLE.
  - link_out_data is 0 whenever strb=0.
  - Minimum word period: BEATS+IDLE_GAP+1 cycles.
- RX FSM, states IDLE, RECV:
  - strb=1 & first=1: store lanes at beat 0, count=1, go to RECV. If already in RECV, also pulse rx_err and restart with this beat.
  - strb=1 & first=0 in RECV: store lanes at position count, count+1.
  - strb=1 & first=0 in IDLE: rx_err pulse, beat discarded.
  - strb=0: no change. Gaps mid-frame are legal; there is no timeout.
  - When beat BEATS-1 is stored:
    - rx_data is updated at that same edge and rx_valid=1 for the following cycle.
    - FSM returns to IDLE.
    - If BEATS=1, every strobed first beat completes a word.
- Latency: accept edge to rx_valid high, in external loopback, is BEATS cycles.
- rx_err and rx_valid are never both high. An errored frame never updates rx_data.

Optional Feature:
- Macro LINK_PARITY_EN.
- When defined:
  - Adds port link_out_par (out, 1): even parity over link_out_data, valid with strb.
  - Adds port link_in_par (in, 1).
  - rx checks each strobed beat. On mismatch: rx_err pulse, frame discarded, RX to IDLE. A mismatching first beat is also discarded.
- When undefined: ports absent, no parity checking; behaviour otherwise identical.

Test Plan:
- DATA_W=16, LANES=4, loopback; send 0xA5C3:
  - link beats 0x3, 0xC, 0x5, 0xA; first=1 on beat 0 only.
  - rx_data=0xA5C3, rx_valid pulses 4 cycles after the accept edge.
  - tx_ready low for 4 cycles.
- Back-to-back 0x1234, 0xFFFF with tx_valid held, IDLE_GAP=2:
  - Second accept exactly 7 cycles after the first.
  - Both words received in order, no rx_err.
- Drive rx with first=1 beat 0x1, then strb gap of 3 cycles, then 0x2, 0x3, 0x4:
  - rx_data=0x4321, rx_valid one pulse.
- Inject first=1 at rx beat 2 of a frame:
  - rx_err pulse; new frame completes correctly; old partial word never appears.
- Assert rst during tx beat 1:
  - strb=0 the next cycle; tx_ready=1 one cycle after rst drops.
  - Receiver sees no rx_valid for the partial frame.
- With LINK_PARITY_EN, flip link_in_par on beat 3:
  - rx_err pulse; rx_data keeps its previous value; next clean frame is received.
